// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with first-word-fall-through read port, fill count, almost flags and sticky errors.
// Latency: a write at edge N is visible on read_data after N; when empty, a simultaneous read/write bypasses in 0 cycles.
// Backpressure: none; a request is accepted or dropped in the same cycle and a drop raises overflow/underflow.
module fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 2,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  clear_err,
    input  logic                  write_en,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  read_en,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] AF_THRESH = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_THRESH = (ADDR_WIDTH+1)'(AE_LEVEL);
    localparam logic [ADDR_WIDTH:0] PTR_ONE   = (ADDR_WIDTH+1)'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic                  wr_accept;
    logic                  rd_accept;
    logic                  wr_fire;
    logic                  rd_fire;
    logic                  bypass;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;

    assign wr_addr = wr_ptr_q[ADDR_WIDTH-1:0];
    assign rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];

    // Status is derived purely from the registered pointers.
    assign count        = wr_ptr_q - rd_ptr_q;
    assign empty        = (wr_ptr_q == rd_ptr_q);
    assign full         = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) && (wr_addr == rd_addr);
    assign almost_full  = (count >= AF_THRESH);
    assign almost_empty = (count <= AE_THRESH);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // A read frees a slot for a write when full, and a write feeds a read when empty.
    assign wr_accept = write_en && (!full || read_en);
    assign rd_accept = read_en && (!empty || write_en);
    assign wr_fire   = wr_accept && !flush;
    assign rd_fire   = rd_accept && !flush;
    assign bypass    = empty && write_en && read_en;

    always_comb begin
        read_data = '0;
        if (bypass) begin
            read_data = write_data;
        end else if (!empty) begin
            read_data = mem_q[rd_addr];
        end
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_fire) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (rd_fire) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
        end

        if (clear_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        // Error events override a coincident clear; flush suppresses them.
        if (!flush && write_en && !wr_accept) begin
            overflow_d = 1'b1;
        end
        if (!flush && read_en && !rd_accept) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage carries no reset; the zero-when-empty read rule masks stale words.
    always_ff @(posedge clk) begin
        if (!rst && wr_fire) begin
            mem_q[wr_addr] <= write_data;
        end
    end

endmodule

// File: tb/tb_fifo_param.sv
module tb_fifo_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       clear_err;
    logic       write_en;
    logic [7:0] write_data;
    logic       read_en;
    logic [7:0] read_data;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;

    int checks   = 0;
    int failures = 0;

    fifo_param #(
        .DATA_WIDTH(8),
        .DEPTH     (8),
        .AF_LEVEL  (6),
        .AE_LEVEL  (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .clear_err   (clear_err),
        .write_en    (write_en),
        .write_data  (write_data),
        .read_en     (read_en),
        .read_data   (read_data),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge and stay stable across the next one.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        write_en  = 1'b0;
        read_en   = 1'b0;
        flush     = 1'b0;
        clear_err = 1'b0;
        rst       = 1'b0;
    endtask

    task automatic fill(input logic [7:0] base);
        for (int i = 0; i < 8; i++) begin
            write_en   = 1'b1;
            write_data = base + 8'(i);
            tick();
        end
        write_en = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_empty"}, 32'(empty), 32'd1);
        check({tag, "_full"}, 32'(full), 32'd0);
        check({tag, "_ae"}, 32'(almost_empty), 32'd1);
        check({tag, "_af"}, 32'(almost_full), 32'd0);
        check({tag, "_ovf"}, 32'(overflow), 32'd0);
        check({tag, "_udf"}, 32'(underflow), 32'd0);
        check({tag, "_rdata"}, 32'(read_data), 32'd0);
    endtask

    initial begin
        idle();
        write_data = 8'h00;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_reset_state("rst");

        // Fill 0x11..0x18 and watch the threshold flags move.
        for (int i = 0; i < 8; i++) begin
            write_en   = 1'b1;
            write_data = 8'h11 + 8'(i);
            tick();
            check($sformatf("fill_count_%0d", i), 32'(count), 32'(i + 1));
            check($sformatf("fill_ae_%0d", i), 32'(almost_empty), 32'((i + 1) <= 2));
            check($sformatf("fill_af_%0d", i), 32'(almost_full), 32'((i + 1) >= 6));
            check($sformatf("fill_full_%0d", i), 32'(full), 32'((i + 1) == 8));
            check($sformatf("fill_head_%0d", i), 32'(read_data), 32'h11);
        end
        write_data = 8'h99;
        tick();
        write_en = 1'b0;
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd8);
        check("ovf_head", 32'(read_data), 32'h11);

        for (int i = 0; i < 8; i++) begin
            read_en = 1'b1;
            #1;
            check($sformatf("drain_data_%0d", i), 32'(read_data), 32'h11 + 32'(i));
            tick();
            check($sformatf("drain_count_%0d", i), 32'(count), 32'(7 - i));
        end
        read_en = 1'b0;
        check("drained_empty", 32'(empty), 32'd1);
        check("drained_rdata", 32'(read_data), 32'd0);

        read_en = 1'b1;
        tick();
        read_en = 1'b0;
        check("udf_set", 32'(underflow), 32'd1);
        check("udf_ovf_kept", 32'(overflow), 32'd1);
        check("udf_count", 32'(count), 32'd0);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("clr_ovf", 32'(overflow), 32'd0);
        check("clr_udf", 32'(underflow), 32'd0);

        // Empty bypass.
        read_en    = 1'b1;
        write_en   = 1'b1;
        write_data = 8'hA5;
        #1;
        check("byp_rdata", 32'(read_data), 32'hA5);
        check("byp_empty_same", 32'(empty), 32'd1);
        tick();
        idle();
        check("byp_empty", 32'(empty), 32'd1);
        check("byp_count", 32'(count), 32'd0);
        check("byp_ovf", 32'(overflow), 32'd0);
        check("byp_udf", 32'(underflow), 32'd0);

        // Full with simultaneous read and write.
        fill(8'h20);
        check("fw_full", 32'(full), 32'd1);
        read_en    = 1'b1;
        write_en   = 1'b1;
        write_data = 8'h5A;
        #1;
        check("fw_head", 32'(read_data), 32'h20);
        tick();
        idle();
        check("fw_count", 32'(count), 32'd8);
        check("fw_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] exp_d;
            exp_d = (i == 7) ? 8'h5A : 8'h21 + 8'(i);
            read_en = 1'b1;
            #1;
            check($sformatf("fw_drain_%0d", i), 32'(read_data), 32'(exp_d));
            tick();
        end
        read_en = 1'b0;
        check("fw_empty", 32'(empty), 32'd1);

        // Repeated fill/drain across the pointer wrap.
        for (int c = 0; c < 3; c++) begin
            fill(8'h40 + 8'(c * 16));
            check($sformatf("wrap_full_%0d", c), 32'(full), 32'd1);
            for (int i = 0; i < 8; i++) begin
                read_en = 1'b1;
                #1;
                check($sformatf("wrap_d_%0d_%0d", c, i), 32'(read_data), 32'h40 + 32'(c * 16 + i));
                tick();
            end
            read_en = 1'b0;
            check($sformatf("wrap_empty_%0d", c), 32'(empty), 32'd1);
        end
        check("wrap_errs", 32'({overflow, underflow}), 32'd0);

        // Flush with a coincident write, error flags held.
        read_en = 1'b1;
        tick();
        read_en = 1'b0;
        check("fl_udf_pre", 32'(underflow), 32'd1);
        for (int i = 0; i < 5; i++) begin
            write_en   = 1'b1;
            write_data = 8'h60 + 8'(i);
            tick();
        end
        write_en = 1'b0;
        check("fl_count_pre", 32'(count), 32'd5);
        flush      = 1'b1;
        write_en   = 1'b1;
        write_data = 8'h77;
        tick();
        idle();
        check("fl_count", 32'(count), 32'd0);
        check("fl_empty", 32'(empty), 32'd1);
        check("fl_rdata", 32'(read_data), 32'd0);
        check("fl_udf_kept", 32'(underflow), 32'd1);
        check("fl_ovf_kept", 32'(overflow), 32'd0);
        write_en   = 1'b1;
        write_data = 8'h33;
        tick();
        write_en = 1'b0;
        check("fl_after_count", 32'(count), 32'd1);
        check("fl_after_head", 32'(read_data), 32'h33);

        // Mid-stream reset with 4 entries held and overflow set.
        read_en = 1'b1;
        tick();
        read_en = 1'b0;
        fill(8'h80);
        write_en   = 1'b1;
        write_data = 8'hEE;
        tick();
        write_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            read_en = 1'b1;
            tick();
        end
        read_en = 1'b0;
        check("mr_count_pre", 32'(count), 32'd4);
        check("mr_ovf_pre", 32'(overflow), 32'd1);
        check("mr_head_pre", 32'(read_data), 32'h84);
        rst        = 1'b1;
        write_en   = 1'b1;
        write_data = 8'hCC;
        tick();
        idle();
        check_reset_state("mr");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_param.md
# fifo_param

Parametrised synchronous FIFO, the successor to the team's fixed 4-entry, 4-bit buffer. Width and depth are generalised, and it adds fill count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous flush. It keeps the first-word-fall-through read port and the empty-bypass behaviour of the previous generation. It sits between producer and consumer stages in the same clock domain.

## Interface
- DATA_WIDTH, default 8: width of write_data/read_data; ≥ 1.
- DEPTH, default 8: number of entries; power of two, ≥ 2.
- AF_LEVEL, default 6: almost_full asserts when count ≥ AF_LEVEL; range 1..DEPTH.
- AE_LEVEL, default 2: almost_empty asserts when count ≤ AE_LEVEL; range 0..DEPTH-1.
- ADDR_WIDTH (derived, not overridable) = $clog2(DEPTH).
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  synchronous empty request.
- clear_err  in  1  clears overflow/underflow.
- write_en  in  1  write request.
- write_data  in  DATA_WIDTH  data to enqueue.
- read_en  in  1  read request; pops the word shown on read_data.
- read_data  out  DATA_WIDTH  head of queue (combinational, FWFT).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_LEVEL.
- almost_empty  out  1  count ≤ AE_LEVEL.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was dropped.
- underflow  out  1  sticky: a read was refused.

## Operation
- Storage: DEPTH × DATA_WIDTH register array. Read and write pointers are ADDR_WIDTH+1 bits. The low bits index the array. The MSB is the wrap bit.
- full is asserted when the wrap bits differ and the low bits are equal. empty is asserted when the pointers are equal. count = wr_ptr − rd_ptr, taken modulo 2^(ADDR_WIDTH+1).
- The pointers wrap naturally at 2·DEPTH. No special handling is required.
- Write is accepted when write_en && (!full || read_en). On acceptance, mem[wr_ptr low bits] ← write_data and wr_ptr increments.
- Read is accepted when read_en && (!empty || write_en). On acceptance, rd_ptr increments.
- Full, with read and write in the same cycle: both are accepted. read_data shows the old head. The new word lands in the freed slot. count stays DEPTH.
- Empty, with read and write in the same cycle (bypass): read_data = write_data combinationally. Both pointers advance and count stays 0.
- read_data:
  - bypass case: write_data;
  - else, when empty: all zeros;
  - otherwise: mem[rd_ptr low bits].
- A write request while full and not reading is dropped, and overflow is set. The array and pointers are unchanged.
- A read request while empty and not writing is refused, and underflow is set.
- Error flags are sticky until clear_err. If clear_err coincides with a new error event, set wins.
- flush clears both pointers. It has priority over read/write in the same cycle: those requests are ignored and raise no error flags. flush does not clear the array or the error flags.
- rst clears the pointers and both error flags, and has priority over everything. The array is not reset; the zero read_data rule when empty hides any stale contents.

## Timing
- Write-to-read latency: a word written at edge N is visible on read_data after edge N (empty deasserts the same cycle). In the bypass case, latency is 0 cycles.
- full, empty, almost_*, count and the error flags are all registered-state derived and update one edge after the causing request.
- read_data is combinational from the pointers, the array, write_en, read_en and write_data.
- Reset values, after the rst edge:
  - count = 0, empty = 1, full = 0;
  - almost_empty = 1, almost_full = 0;
  - overflow = 0, underflow = 0, read_data = 0.
- Reset or flush asserted mid-stream: at the next edge the FIFO is empty, and in-flight requests in that cycle are discarded.
- No handshake stalls: the FIFO accepts or rejects a request within the same cycle.

## Test plan
- Reset, then write 0x11..0x18 on consecutive cycles (defaults: depth 8, AF_LEVEL 6, AE_LEVEL 2):
  - almost_empty drops once count = 3;
  - almost_full rises once count = 6;
  - full rises once count = 8.
  - A 9th write of 0x99 sets overflow, and count stays 8.
- From full, read 8 times: read_data must be 0x11..0x18 in order, then empty = 1 and read_data = 0. A further read sets underflow. Then pulse clear_err and both flags read 0.
- Empty, with read_en = write_en = 1 and write_data = 0xA5 for one cycle: read_data = 0xA5 that cycle, empty stays 1, count stays 0, and no error flags are set.
- Full, with simultaneous read and write of 0x5A: the old head pops, count stays 8, and no overflow. Then read out fully: 0x5A appears last. Run ≥ 3 full fill/drain cycles to exercise pointer wrap.
- With 5 entries held, assert flush together with write_en:
  - next cycle, count = 0 and empty = 1;
  - the write is discarded;
  - the error flags are unchanged.
- Mid-stream rst, with 4 entries and overflow set: next cycle, all outputs are at their reset values.
